btn_debounce_fsm: RTL and testbench



---
 rtl/btn_debounce_fsm_pkg.sv | 17 +
 rtl/btn_debounce_fsm_sync_ff.sv | 29 ++
 rtl/btn_debounce_fsm.sv | 147 ++++++++++++++
 tb/tb_btn_debounce_fsm.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/btn_debounce_fsm_pkg.sv
// Shared definitions for the tick-driven button debouncer: FSM state encoding
// and the counter-width helper used to size the stable and hold counters.
package btn_debounce_fsm_pkg;

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } state_e;

  // Bits needed to hold values 0..max_val without wrapping.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_fsm_sync_ff.sv
// Multi-stage input synchronizer for the raw button; clocked every cycle,
// synchronous active-low reset clears every stage to 0.
module btn_debounce_fsm_sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/btn_debounce_fsm.sv
// Tick-sampled push-button debouncer: registered clean level plus one-cycle
// rise, fall and long-press strobes; outputs update on the edge after the committing tick.
module btn_debounce_fsm
  import btn_debounce_fsm_pkg::*;
#(
  parameter int STABLE_TICKS = 20,
  parameter int LONG_TICKS   = 1000,
  parameter int SYNC_STAGES  = 2
) (
  input  logic clk_100Mhz,
  input  logic rst_n,
  input  logic tick,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall,
  output logic long_press
);

  localparam int CW = cnt_width(STABLE_TICKS);
  localparam int HW = cnt_width(LONG_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_TICKS);

  logic          btn_s;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          lp_q, lp_d;
  logic          commit_hi, commit_lo;

  btn_debounce_fsm_sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk_100Mhz),
    .rst_n(rst_n),
    .d    (btn_in),
    .q    (btn_s)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    level_d   = level_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    lp_d      = 1'b0;
    commit_hi = 1'b0;
    commit_lo = 1'b0;

    if (tick) begin
      unique case (state_q)
        LOW: begin
          if (btn_s) begin
            if (STABLE_TICKS == 1) begin
              commit_hi = 1'b1;
            end else begin
              state_d = WAIT_HIGH;
              cnt_d   = CW'(1);
            end
          end
        end
        WAIT_HIGH: begin
          if (!btn_s) begin
            state_d = LOW;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            commit_hi = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        HIGH: begin
          if (!btn_s) begin
            if (STABLE_TICKS == 1) begin
              commit_lo = 1'b1;
            end else begin
              state_d = WAIT_LOW;
              cnt_d   = CW'(1);
            end
          end
        end
        WAIT_LOW: begin
          if (btn_s) begin
            state_d = HIGH;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            commit_lo = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      endcase

      if (commit_hi) begin
        state_d = HIGH;
        cnt_d   = '0;
        hold_d  = '0;
        level_d = 1'b1;
        rise_d  = 1'b1;
      end
      if (commit_lo) begin
        state_d = LOW;
        cnt_d   = '0;
        hold_d  = '0;
        level_d = 1'b0;
        fall_d  = 1'b0 | 1'b1;
      end

      // Hold keeps counting through a release bounce; saturation makes long_press single-shot.
      if ((state_q == HIGH || state_q == WAIT_LOW) && !commit_lo && hold_q != HOLD_MAX) begin
        hold_d = hold_q + HW'(1);
        lp_d   = (hold_d == HOLD_MAX);
      end
    end
  end

  always_ff @(posedge clk_100Mhz) begin
    if (!rst_n) begin
      state_q <= LOW;
      cnt_q   <= '0;
      hold_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      lp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      lp_q    <= lp_d;
    end
  end

  assign btn_level  = level_q;
  assign btn_rise   = rise_q;
  assign btn_fall   = fall_q;
  assign long_press = lp_q;

endmodule

// File: tb/tb_btn_debounce_fsm.sv
// Bench for btn_debounce_fsm: two instances (STABLE=4/LONG=10 and STABLE=1/LONG=1)
// driven together and checked every cycle against a run-length model.
module tb_btn_debounce_fsm;

  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic tick;
  logic btn_in;
  logic [1:0] d_level, d_rise, d_fall, d_lp;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int tick_div = 0;
  logic tick_always = 1'b0;
  int ticks_total = 0;

  int n_rise[2], n_fall[2], n_lp[2];
  int t_rise[2], t_fall[2], t_lp[2];

  // Model state: committed level, length of the current run of samples that
  // disagree with it, and ticks spent committed-high in this press.
  bit   hist[$];
  logic m_level[2];
  int   m_run[2];
  int   m_hold[2];
  logic e_rise[2], e_fall[2], e_lp[2];

  always #5 clk = ~clk;

  btn_debounce_fsm #(.STABLE_TICKS(4), .LONG_TICKS(10), .SYNC_STAGES(SYNC)) dut0 (
    .clk_100Mhz(clk), .rst_n(rst_n), .tick(tick), .btn_in(btn_in),
    .btn_level(d_level[0]), .btn_rise(d_rise[0]), .btn_fall(d_fall[0]), .long_press(d_lp[0])
  );

  btn_debounce_fsm #(.STABLE_TICKS(1), .LONG_TICKS(1), .SYNC_STAGES(SYNC)) dut1 (
    .clk_100Mhz(clk), .rst_n(rst_n), .tick(tick), .btn_in(btn_in),
    .btn_level(d_level[1]), .btn_rise(d_rise[1]), .btn_fall(d_fall[1]), .long_press(d_lp[1])
  );

  function automatic int stab_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic int long_of(input int i);
    return (i == 0) ? 10 : 1;
  endfunction

  always @(posedge clk) begin
    automatic logic b_s;
    b_s = (hist.size() >= SYNC) ? hist[0] : 1'b0;
    if (!rst_n) begin
      hist.delete();
      for (int i = 0; i < 2; i++) begin
        m_level[i] <= 1'b0; m_run[i] <= 0; m_hold[i] <= 0;
        e_rise[i] <= 1'b0; e_fall[i] <= 1'b0; e_lp[i] <= 1'b0;
      end
    end else begin
      hist.push_back(btn_in);
      if (hist.size() > SYNC) void'(hist.pop_front());
      for (int i = 0; i < 2; i++) begin
        automatic logic lv = m_level[i];
        automatic int   rn = m_run[i];
        automatic int   hd = m_hold[i];
        automatic logic r = 1'b0, f = 1'b0, lp = 1'b0, done = 1'b0;
        if (tick) begin
          if (b_s != lv) begin
            rn = rn + 1;
            if (rn == stab_of(i)) begin
              done = 1'b1; r = b_s; f = !b_s; lv = b_s; rn = 0; hd = 0;
            end
          end else begin
            rn = 0;
          end
          if (!done && lv && hd < long_of(i)) begin
            hd = hd + 1;
            lp = (hd == long_of(i));
          end
        end
        m_level[i] <= lv; m_run[i] <= rn; m_hold[i] <= hd;
        e_rise[i] <= r; e_fall[i] <= f; e_lp[i] <= lp;
      end
    end
  end

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input int i, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[dut%0d] at cycle %0d: got %b, expected %b", name, i, cyc, act, exp);
    end
  endtask

  // One clock: compare outputs of the edge just taken, log strobes, drive the next tick.
  task automatic step();
    @(negedge clk);
    if (tick && rst_n) ticks_total++;
    for (int i = 0; i < 2; i++) begin
      chk_bit("btn_level", i, d_level[i], m_level[i]);
      chk_bit("btn_rise", i, d_rise[i], e_rise[i]);
      chk_bit("btn_fall", i, d_fall[i], e_fall[i]);
      chk_bit("long_press", i, d_lp[i], e_lp[i]);
      if (d_rise[i]) begin n_rise[i]++; t_rise[i] = ticks_total; end
      if (d_fall[i]) begin n_fall[i]++; t_fall[i] = ticks_total; end
      if (d_lp[i])   begin n_lp[i]++;   t_lp[i]   = ticks_total; end
    end
    cyc++;
    tick_div = (tick_div == 4) ? 0 : tick_div + 1;
    tick = tick_always | (tick_div == 4);
  endtask

  // Returns at the falling edge just after the n-th tick edge.
  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      int guard;
      guard = 0;
      do begin
        step();
        guard++;
      end while (!tick && guard < 20);
      if (!tick) begin
        n_fail++;
        $display("FAIL tick_timeout at cycle %0d: got no tick, expected one within 20 cycles", cyc);
      end
      step();
    end
  endtask

  initial begin
    int t0, r0, r1, f0, f1, l0, l1;
    for (int i = 0; i < 2; i++) begin
      n_rise[i] = 0; n_fall[i] = 0; n_lp[i] = 0; t_rise[i] = 0; t_fall[i] = 0; t_lp[i] = 0;
    end
    rst_n = 1'b0; btn_in = 1'b0; tick = 1'b0;
    repeat (3) step();
    chk_int("reset_level0", int'(d_level[0]), 0);
    chk_int("reset_level1", int'(d_level[1]), 0);
    rst_n = 1'b1;
    wait_ticks(2);

    // Clean press
    t0 = ticks_total; r0 = n_rise[0]; r1 = n_rise[1]; f0 = n_fall[0]; l1 = n_lp[1];
    btn_in = 1'b1;
    wait_ticks(6);
    chk_int("press_rise_count0", n_rise[0] - r0, 1);
    chk_int("press_rise_tick0", t_rise[0] - t0, 4);
    chk_int("press_rise_tick1", t_rise[1] - t0, 1);
    chk_int("press_fall_count0", n_fall[0] - f0, 0);
    chk_int("press_level0", int'(d_level[0]), 1);
    chk_int("press_lp_count1", n_lp[1] - l1, 1);
    chk_int("press_lp_delay1", t_lp[1] - t_rise[1], 1);
    t0 = ticks_total; f0 = n_fall[0];
    btn_in = 1'b0;
    wait_ticks(6);
    chk_int("release_fall_tick0", t_fall[0] - t0, 4);
    chk_int("release_fall_count0", n_fall[0] - f0, 1);

    // Bounce: 2 high samples, 1 low, then steady high
    r0 = n_rise[0]; r1 = n_rise[1];
    btn_in = 1'b1; wait_ticks(2);
    btn_in = 1'b0; wait_ticks(1);
    t0 = ticks_total;
    btn_in = 1'b1; wait_ticks(6);
    chk_int("bounce_rise_count0", n_rise[0] - r0, 1);
    chk_int("bounce_rise_tick0", t_rise[0] - t0, 4);
    chk_int("bounce_rise_count1", n_rise[1] - r1, 2);
    btn_in = 1'b0; wait_ticks(6);

    // Long press: 15 ticks held after commit, then release
    l0 = n_lp[0]; f0 = n_fall[0];
    btn_in = 1'b1; wait_ticks(4 + 15);
    chk_int("long_lp_count0", n_lp[0] - l0, 1);
    chk_int("long_lp_delay0", t_lp[0] - t_rise[0], 10);
    t0 = ticks_total;
    btn_in = 1'b0; wait_ticks(6);
    chk_int("long_fall_tick0", t_fall[0] - t0, 4);
    chk_int("long_fall_count0", n_fall[0] - f0, 1);
    chk_int("long_lp_once0", n_lp[0] - l0, 1);

    // Glitch between ticks is never sampled
    r0 = n_rise[0]; r1 = n_rise[1];
    btn_in = 1'b1; step(); step();
    btn_in = 1'b0; wait_ticks(3);
    chk_int("glitch_rise0", n_rise[0] - r0, 0);
    chk_int("glitch_rise1", n_rise[1] - r1, 0);
    chk_int("glitch_level0", int'(d_level[0]), 0);

    // Reset in the middle of a debounce
    btn_in = 1'b1; wait_ticks(3);
    f1 = n_fall[1];
    rst_n = 1'b0; step();
    chk_int("midrst_level0", int'(d_level[0]), 0);
    chk_int("midrst_level1", int'(d_level[1]), 0);
    rst_n = 1'b1;
    t0 = ticks_total; r0 = n_rise[0];
    wait_ticks(6);
    chk_int("midrst_rise_tick0", t_rise[0] - t0, 4);
    chk_int("midrst_rise_count0", n_rise[0] - r0, 1);
    chk_int("midrst_rise_tick1", t_rise[1] - t0, 1);
    chk_int("midrst_no_fall1", n_fall[1] - f1, 0);
    btn_in = 1'b0; wait_ticks(6);

    // Tick held high: every cycle is a sample
    r0 = n_rise[0]; r1 = n_rise[1]; f0 = n_fall[0]; f1 = n_fall[1]; l0 = n_lp[0]; l1 = n_lp[1];
    tick_always = 1'b1; tick = 1'b1;
    btn_in = 1'b1;
    repeat (10) step();
    chk_int("cont_rise_count0", n_rise[0] - r0, 1);
    chk_int("cont_rise_count1", n_rise[1] - r1, 1);
    repeat (14) step();
    chk_int("cont_lp_count0", n_lp[0] - l0, 1);
    chk_int("cont_lp_count1", n_lp[1] - l1, 1);
    btn_in = 1'b0;
    repeat (8) step();
    chk_int("cont_fall_count0", n_fall[0] - f0, 1);
    chk_int("cont_fall_count1", n_fall[1] - f1, 1);
    tick_always = 1'b0;
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
